// File: rtl/fpnew_norm_seq.sv
// Multi-cycle normalizer in front of the FP rounder: shifts a wide mantissa by at most ShiftStep bits per cycle.
// Optional macro FPNEW_NORM_FASTZERO_EN: a zero mantissa skips the shift state and goes straight to DONE.
module fpnew_norm_seq #(
    parameter int unsigned MantWidth = 50,
    parameter int unsigned PrecBits  = 24,
    parameter int unsigned ExpWidth  = 10,
    parameter int unsigned ShiftStep = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [MantWidth-1:0] mantissa_i,
    input  logic [ExpWidth-1:0]  exponent_i,
    input  logic                 sign_i,
    input  logic [2:0]           rnd_mode_i,
    input  logic                 eff_sub_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PrecBits-1:0]  mant_o,
    output logic [ExpWidth-1:0]  exponent_o,
    output logic [1:0]           round_sticky_bits_o,
    output logic                 sign_o,
    output logic [2:0]           rnd_mode_o,
    output logic                 eff_sub_o
);
    localparam int unsigned AmtWidth = $clog2(MantWidth + 1);
    // Two extra bits so 1-e and e-1 never wrap for any biased exponent
    localparam int unsigned XW = ExpWidth + 2;
    localparam logic signed [XW-1:0] ONE_X  = XW'(1);
    localparam logic signed [XW-1:0] STEP_X = XW'(ShiftStep);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                      state_reg, state_next;
    logic [MantWidth-1:0]        mant_reg, mant_next;
    logic signed [ExpWidth-1:0]  exp_reg, exp_next;
    logic                        sticky_reg, sticky_next;
    logic                        sign_reg;
    logic [2:0]                  rnd_mode_reg;
    logic                        eff_sub_reg;

    logic [AmtWidth-1:0]         lzc;
    logic signed [XW-1:0]        exp_wide, right_dist, left_dist, lzc_x, amt_x;
    logic [AmtWidth-1:0]         step_amt;
    logic                        step_right, step_left;
    logic [MantWidth-1:0]        lost_mask;

    always_comb begin
        lzc = AmtWidth'(MantWidth);
        for (int i = 0; i < int'(MantWidth); i++) begin
            if (mant_reg[i]) lzc = AmtWidth'(int'(MantWidth) - 1 - i);
        end
    end

    // Step distance: right shifts clamp at e=1, left shifts stop at the MSB or at e=1
    always_comb begin
        exp_wide   = XW'(exp_reg);
        right_dist = ONE_X - exp_wide;
        left_dist  = exp_wide - ONE_X;
        lzc_x      = XW'(lzc);
        step_right = (mant_reg != '0) && (exp_wide < ONE_X);
        step_left  = (mant_reg != '0) && !mant_reg[MantWidth-1] && (exp_wide > ONE_X);
        amt_x      = STEP_X;
        if (step_right) begin
            if (right_dist < amt_x) amt_x = right_dist;
        end else if (step_left) begin
            if (lzc_x < amt_x) amt_x = lzc_x;
            if (left_dist < amt_x) amt_x = left_dist;
        end
        step_amt  = AmtWidth'(amt_x);
        lost_mask = ~({MantWidth{1'b1}} << step_amt);
    end

    always_comb begin
        state_next  = state_reg;
        mant_next   = mant_reg;
        exp_next    = exp_reg;
        sticky_next = sticky_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid_i) begin
                    mant_next   = mantissa_i;
                    exp_next    = exponent_i;
                    sticky_next = 1'b0;
`ifdef FPNEW_NORM_FASTZERO_EN
                    state_next  = (mantissa_i == '0) ? DONE : SHIFT;
`else
                    state_next  = SHIFT;
`endif
                end
            end
            SHIFT: begin
                if (step_right) begin
                    mant_next   = mant_reg >> step_amt;
                    exp_next    = exp_reg + ExpWidth'(amt_x);
                    sticky_next = sticky_reg | (|(mant_reg & lost_mask));
                end else if (step_left) begin
                    mant_next = mant_reg << step_amt;
                    exp_next  = exp_reg - ExpWidth'(amt_x);
                end else begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush_i) state_next = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            mant_reg     <= '0;
            exp_reg      <= '0;
            sticky_reg   <= 1'b0;
            sign_reg     <= 1'b0;
            rnd_mode_reg <= 3'b000;
            eff_sub_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mant_reg   <= mant_next;
            exp_reg    <= exp_next;
            sticky_reg <= sticky_next;
            if (state_reg == IDLE && in_valid_i) begin
                sign_reg     <= sign_i;
                rnd_mode_reg <= rnd_mode_i;
                eff_sub_reg  <= eff_sub_i;
            end
        end
    end

    assign in_ready_o          = (state_reg == IDLE);
    assign out_valid_o         = (state_reg == DONE);
    assign mant_o              = mant_reg[MantWidth-1 -: PrecBits];
    assign exponent_o          = mant_reg[MantWidth-1] ? exp_reg : '0;
    assign round_sticky_bits_o = {mant_reg[MantWidth-1-PrecBits],
                                  (|mant_reg[MantWidth-2-PrecBits:0]) | sticky_reg};
    assign sign_o              = sign_reg;
    assign rnd_mode_o          = rnd_mode_reg;
    assign eff_sub_o           = eff_sub_reg;
endmodule

// File: tb/tb_fpnew_norm_seq.sv
// Bench for fpnew_norm_seq: directed vector table, backpressure/flush/reset sequences and random ops vs a closed-form model.
module tb_fpnew_norm_seq;
    localparam int MW = 50;
    localparam int PB = 24;
    localparam int EW = 10;
    localparam int SS = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [MW-1:0] mantissa = '0;
    logic [EW-1:0] exponent = '0;
    logic          sign = 1'b0;
    logic [2:0]    rnd_mode = 3'b000;
    logic          eff_sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PB-1:0] mant_o;
    logic [EW-1:0] exponent_o;
    logic [1:0]    rs_o;
    logic          sign_o;
    logic [2:0]    rnd_mode_o;
    logic          eff_sub_o;

    int checks = 0;
    int failures = 0;

    fpnew_norm_seq #(.MantWidth(MW), .PrecBits(PB), .ExpWidth(EW), .ShiftStep(SS)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .mantissa_i(mantissa), .exponent_i(exponent), .sign_i(sign),
        .rnd_mode_i(rnd_mode), .eff_sub_i(eff_sub),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .mant_o(mant_o), .exponent_o(exponent_o), .round_sticky_bits_o(rs_o),
        .sign_o(sign_o), .rnd_mode_o(rnd_mode_o), .eff_sub_o(eff_sub_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] m;
        int            e;
        int            lat;
        logic [PB-1:0] mo;
        logic [EW-1:0] eo;
        logic [1:0]    rs;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Closed-form result: total shift is known up front; steps are the ShiftStep-sized chunks of it
    function automatic vec_t model(input logic [MW-1:0] m, input int e);
        vec_t r;
        logic [63:0] mw, mf, lost;
        int d, msb, lz, total, steps, ef;
        mw = 64'(m);
        r.m = m;
        r.e = e;
        if (m == '0) begin
            steps = 0; mf = '0; lost = '0; ef = e;
        end else if (e < 1) begin
            d = 1 - e;
            msb = 0;
            for (int i = 0; i < MW; i++) if (m[i]) msb = i;
            steps = (d + SS - 1) / SS;
            if ((msb + SS) / SS < steps) steps = (msb + SS) / SS;
            mf = mw >> d;
            lost = mw ^ ((mw >> d) << d);
            ef = 1;
        end else begin
            lz = 0;
            while (lz < MW && !m[MW-1-lz]) lz++;
            total = (lz < e - 1) ? lz : e - 1;
            steps = (total + SS - 1) / SS;
            mf = mw << total;
            lost = '0;
            ef = e - total;
        end
        r.lat = steps + 2;
`ifdef FPNEW_NORM_FASTZERO_EN
        if (m == '0) r.lat = 1;
`endif
        r.mo = PB'(mf >> (MW - PB));
        r.rs = {mf[MW-1-PB], (|(mf & ((64'd1 << (MW - PB - 1)) - 64'd1))) | (lost != 0)};
        r.eo = mf[MW-1] ? EW'(ef) : '0;
        return r;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_op", 64'(in_ready), 64'd1);
    endtask

    // Handshake in cycle 0, then measure the cycle in which out_valid first appears
    task automatic start_op(input logic [MW-1:0] m, input int e, input logic s,
                            input logic [2:0] rm, input logic es);
        wait_ready();
        mantissa = m; exponent = EW'(e); sign = s; rnd_mode = rm; eff_sub = es;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle_after_accept", {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    task automatic run_and_check(input vec_t v, input logic s, input logic [2:0] rm,
                                 input logic es, input string tag);
        int lat;
        start_op(v.m, v.e, s, rm, es);
        wait_valid(lat);
        $display("%s m=0x%0h e=%0d lat=%0d mant_o=0x%0h exp_o=%0d rs=%b", tag, v.m, v.e, lat,
                 mant_o, exponent_o, rs_o);
        check({tag, "_latency"}, 64'(lat), 64'(v.lat));
        check({tag, "_mant"}, 64'(mant_o), 64'(v.mo));
        check({tag, "_exp"}, 64'(exponent_o), 64'(v.eo));
        check({tag, "_rs"}, 64'(rs_o), 64'(v.rs));
        check({tag, "_pass"}, {59'd0, sign_o, rnd_mode_o, eff_sub_o}, {59'd0, s, rm, es});
        accept();
    endtask

    initial begin
        vec_t vecs[6];
        vec_t zero_v;
        vec_t rv;
        int lat;
        int zlat;
        logic [63:0] rnd;
        logic [MW-1:0] rm_m;
        int re;

`ifdef FPNEW_NORM_FASTZERO_EN
        zlat = 1;
`else
        zlat = 2;
`endif
        vecs[0] = '{m: 50'd1 << 49,               e: 100, lat: 2, mo: 24'h800000, eo: 10'd100, rs: 2'b00};
        vecs[1] = '{m: 50'd1 << 29,               e: 100, lat: 5, mo: 24'h800000, eo: 10'd80,  rs: 2'b00};
        vecs[2] = '{m: 50'd1 << 29,               e: 5,   lat: 3, mo: 24'h000080, eo: 10'd0,   rs: 2'b00};
        vecs[3] = '{m: (50'd1 << 49) | 50'd1,     e: -3,  lat: 3, mo: 24'h080000, eo: 10'd0,   rs: 2'b01};
        vecs[4] = '{m: (50'd1 << 49) | (50'd1 << 25) | 50'd1, e: 50, lat: 2, mo: 24'h800000, eo: 10'd50, rs: 2'b11};
        vecs[5] = '{m: 50'd3,                     e: -400, lat: 3, mo: 24'h000000, eo: 10'd0,  rs: 2'b01};
        zero_v  = '{m: 50'd0,                     e: 7,   lat: zlat, mo: 24'h0, eo: 10'd0, rs: 2'b00};

        #1;
        check("reset_outputs", {mant_o, exponent_o, rs_o, sign_o, rnd_mode_o, eff_sub_o, out_valid},
              64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++)
            run_and_check(vecs[i], i[0], 3'(i), ~i[0], $sformatf("vec%0d", i));

        // Backpressure: results and handshake signals must hold while out_ready is low
        start_op(vecs[1].m, vecs[1].e, 1'b1, 3'd4, 1'b0);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'(vecs[1].lat));
        for (int c = 0; c < 5; c++) begin
            check("bp_hold", {28'd0, out_valid, in_ready, mant_o, exponent_o, rs_o},
                  {28'd0, 1'b1, 1'b0, 24'h800000, 10'd80, 2'b00});
            @(posedge clk); #1;
        end
        $display("backpressure held 5 cycles mant_o=0x%0h exp_o=%0d", mant_o, exponent_o);
        accept();

        // Flush during SHIFT abandons the operation
        start_op(vecs[1].m, vecs[1].e, 1'b0, 3'd0, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", {62'd0, in_ready, out_valid}, 64'b10);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            check("flush_no_valid", 64'(out_valid), 64'd0);
        end
        $display("flush during SHIFT in_ready=%b out_valid=%b", in_ready, out_valid);

        // Asynchronous reset in the middle of a multi-step shift
        start_op(vecs[1].m, vecs[1].e, 1'b1, 3'd7, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", {mant_o, exponent_o, rs_o, sign_o, rnd_mode_o, eff_sub_o, in_ready, out_valid},
              64'b10);
        $display("async reset mid-shift in_ready=%b out_valid=%b", in_ready, out_valid);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_and_check(zero_v, 1'b1, 3'd2, 1'b0, "zero");

        for (int n = 0; n < 40; n++) begin
            rnd  = {$urandom(), $urandom()};
            rm_m = MW'(rnd) >> $urandom_range(0, MW);
            re   = (n % 10 == 9) ? -int'($urandom_range(0, 500)) : int'($urandom_range(0, 180)) - 60;
            rv   = model(rm_m, re);
            run_and_check(rv, 1'($urandom()), 3'($urandom()), 1'($urandom()), $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
